// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the memory access unit: FSM states, access size codes
// and the sign/size mask presented to the data memory.
package mem_access_unit_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_ACK  = 3'd2,
    WAIT_DONE = 3'd3,
    RESP      = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    SIZE_BYTE    = 2'd0,
    SIZE_HALF    = 2'd1,
    SIZE_WORD    = 2'd2,
    SIZE_ILLEGAL = 2'd3
  } size_e;

  // Byte-lane enables in the low three bits; bit 3 carries the sign request.
  localparam logic [2:0] MASK_BYTE = 3'b001;
  localparam logic [2:0] MASK_HALF = 3'b011;
  localparam logic [2:0] MASK_WORD = 3'b111;

  function automatic logic [3:0] sign_mask_enc(input logic is_store,
                                               input logic is_signed,
                                               input logic [1:0] size);
    logic [2:0] mask;
    case (size)
      SIZE_BYTE: mask = MASK_BYTE;
      SIZE_HALF: mask = MASK_HALF;
      SIZE_WORD: mask = MASK_WORD;
      default:   mask = 3'b000;
    endcase
    return {is_signed & ~is_store, mask};
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response handshake bundle between a requester and the access unit.
interface mem_access_unit_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_signed;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_size, req_signed, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_size, req_signed, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/mem_access_unit_align_check.sv
// Combinational legality check of an access: illegal size code, or an address
// that is not a multiple of the access width.
module mem_align_check
  import mem_access_unit_pkg::*;
(
  input  logic [1:0] size,
  input  logic [1:0] addr_lo,
  output logic       misaligned,
  output logic       illegal
);

  always_comb begin
    misaligned = 1'b0;
    illegal    = 1'b0;
    case (size)
      SIZE_HALF: misaligned = addr_lo[0];
      SIZE_WORD: misaligned = (addr_lo != 2'b00);
      SIZE_ILLEGAL: illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store unit: accepts one request, drives a one-cycle
// read/write strobe into a stall-handshaked memory, and returns one response.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_access_unit_if.slave  bus,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_write_data,
  output logic              mem_memwrite,
  output logic              mem_memread,
  output logic [3:0]        mem_sign_mask,
  input  logic [31:0]       mem_read_data,
  input  logic              mem_clk_stall
);

  localparam int unsigned    CNT_W   = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic              we_q, we_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_mask_q, mem_mask_d;
  logic              mem_rd_q, mem_rd_d;
  logic              mem_wr_q, mem_wr_d;
  logic              misaligned, illegal;
  logic              accept;

  mem_align_check u_align (
    .size       (bus.req_size),
    .addr_lo    (bus.req_addr[1:0]),
    .misaligned (misaligned),
    .illegal    (illegal)
  );

  assign accept  = bus.req_valid & req_ready_q;
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  // NOTE: every *_d is given its held value first so no path through the case infers a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_mask_d  = mem_mask_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          we_d = bus.req_we;
          if (misaligned || illegal) begin
            state_d     = RESP;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            state_d     = ISSUE;
            cnt_d       = '0;
            mem_addr_d  = bus.req_addr;
            mem_wdata_d = bus.req_wdata;
            mem_mask_d  = sign_mask_enc(bus.req_we, bus.req_signed, bus.req_size);
          end
        end
      end
      ISSUE: state_d = WAIT_ACK;
      WAIT_ACK: begin
        cnt_d = cnt_inc;
        if (mem_clk_stall) begin
          state_d = WAIT_DONE;
        end else if (cnt_inc == CNT_MAX) begin
          state_d     = RESP;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end
      end
      WAIT_DONE: begin
        cnt_d = cnt_inc;
        // A completing memory wins over a timeout landing on the same cycle.
        if (!mem_clk_stall) begin
          state_d     = RESP;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = we_q ? 32'h0 : mem_read_data;
        end else if (cnt_inc == CNT_MAX) begin
          state_d     = RESP;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Handshake and strobe outputs are registered versions of the next state.
    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
    mem_rd_d    = (state_d == ISSUE) & ~we_d;
    mem_wr_d    = (state_d == ISSUE) &  we_d;
  end

  // NOTE: sequential state uses <= so every flop samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_mask_q  <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_mask_q  <= mem_mask_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.rsp_rdata  = rsp_rdata_q;
  assign mem_addr       = mem_addr_q;
  assign mem_write_data = mem_wdata_q;
  assign mem_sign_mask  = mem_mask_q;
  assign mem_memread    = mem_rd_q;
  assign mem_memwrite   = mem_wr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural stall-handshake memory.
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_access_unit_if bus ();

  logic [31:0] mem_addr, mem_write_data, mem_read_data;
  logic        mem_memwrite, mem_memread, mem_clk_stall;
  logic [3:0]  mem_sign_mask;

  mem_access_unit #(.TIMEOUT_CYCLES(15)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_memwrite   (mem_memwrite),
    .mem_memread    (mem_memread),
    .mem_sign_mask  (mem_sign_mask),
    .mem_read_data  (mem_read_data),
    .mem_clk_stall  (mem_clk_stall)
  );

  int total = 0;
  int bad   = 0;

  // Memory model controls, written by the tests.
  logic [31:0] rd_value  = 32'h0;
  int          stall_len = 2;
  logic        mem_dead  = 1'b0;

  // Strobe pulse counters; tests compare deltas.
  int rd_pulses = 0;
  int wr_pulses = 0;
  always @(negedge clk) begin
    if (mem_memread)  rd_pulses++;
    if (mem_memwrite) wr_pulses++;
  end

  // Memory: raises stall one cycle after the strobe, drops it stall_len cycles later.
  initial begin
    mem_clk_stall = 1'b0;
    mem_read_data = 32'h0;
    forever begin
      @(negedge clk);
      if (!mem_dead && (mem_memread || mem_memwrite)) begin
        @(posedge clk);
        #1 mem_clk_stall = 1'b1;
        mem_read_data = 32'h0;
        repeat (stall_len) @(posedge clk);
        #1 mem_clk_stall = 1'b0;
        mem_read_data = rd_value;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // All tasks start and end at 1 time unit after a rising edge.
  task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [1:0] size, input logic sgn);
    total++;
    if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL req_ready_before_req: got %b want 1", bus.req_ready); end
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.req_size   = size;
    bus.req_signed = sgn;
    @(posedge clk); #1;
    bus.req_valid  = 1'b0;
  endtask

  // Latency counts rising edges from the handshake edge (inclusive) to rsp_valid.
  task automatic wait_rsp(output int lat);
    lat = 1;
    while (bus.rsp_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic finish_rsp(input string name);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    total++;
    if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL %s_rsp_drop: got %b want 0", name, bus.rsp_valid); end
    total++;
    if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL %s_ready_back: got %b want 1", name, bus.req_ready); end
  endtask

  task automatic settle_mem;
    int n = 0;
    while (mem_clk_stall && n < 50) begin @(posedge clk); #1; n++; end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.req_size = 2'd0; bus.req_signed = 1'b0; bus.rsp_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL rst_req_ready: got %b want 1", bus.req_ready); end
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid: got %b want 0", bus.rsp_valid); end
    total++; if (bus.rsp_err !== 1'b0) begin bad++; $display("FAIL rst_rsp_err: got %b want 0", bus.rsp_err); end
    total++; if (bus.rsp_rdata !== 32'h0) begin bad++; $display("FAIL rst_rsp_rdata: got %h want 0", bus.rsp_rdata); end
    total++; if ({mem_memread, mem_memwrite} !== 2'b00) begin bad++; $display("FAIL rst_strobes: got %b want 00", {mem_memread, mem_memwrite}); end
    total++; if (mem_addr !== 32'h0 || mem_write_data !== 32'h0) begin bad++; $display("FAIL rst_mem_bus: got %h/%h want 0/0", mem_addr, mem_write_data); end
    total++; if (mem_sign_mask !== 4'h0) begin bad++; $display("FAIL rst_sign_mask: got %h want 0", mem_sign_mask); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_load_word;
    int lat, rd0, wr0;
    rd0 = rd_pulses; wr0 = wr_pulses;
    rd_value = 32'h8000_0001; stall_len = 2;
    send(1'b0, 32'h0000_4004, 32'h0, 2'd2, 1'b1);
    total++; if (mem_memread !== 1'b1) begin bad++; $display("FAIL lw_memread_issue: got %b want 1", mem_memread); end
    wait_rsp(lat);
    total++; if (lat !== 5) begin bad++; $display("FAIL lw_latency: got %0d want 5", lat); end
    total++; if (bus.rsp_rdata !== 32'h8000_0001) begin bad++; $display("FAIL lw_rdata: got %h want 80000001", bus.rsp_rdata); end
    total++; if (bus.rsp_err !== 1'b0) begin bad++; $display("FAIL lw_err: got %b want 0", bus.rsp_err); end
    total++; if (mem_sign_mask !== 4'hF) begin bad++; $display("FAIL lw_sign_mask: got %h want f", mem_sign_mask); end
    total++; if (mem_addr !== 32'h0000_4004) begin bad++; $display("FAIL lw_addr: got %h want 00004004", mem_addr); end
    total++; if (rd_pulses - rd0 !== 1 || wr_pulses - wr0 !== 0) begin bad++; $display("FAIL lw_pulses: got rd=%0d wr=%0d want rd=1 wr=0", rd_pulses - rd0, wr_pulses - wr0); end
    finish_rsp("lw");
    settle_mem();
  endtask

  task automatic test_store_byte;
    int lat, rd0, wr0;
    rd0 = rd_pulses; wr0 = wr_pulses;
    rd_value = 32'hDEAD_BEEF; stall_len = 2;
    // req_signed set on a store must not reach mask bit 3.
    send(1'b1, 32'h0000_2000, 32'h0000_00A5, 2'd0, 1'b1);
    wait_rsp(lat);
    total++; if (lat !== 5) begin bad++; $display("FAIL sb_latency: got %0d want 5", lat); end
    total++; if (mem_sign_mask !== 4'h1) begin bad++; $display("FAIL sb_sign_mask: got %h want 1", mem_sign_mask); end
    total++; if (mem_write_data !== 32'h0000_00A5) begin bad++; $display("FAIL sb_wdata: got %h want 000000a5", mem_write_data); end
    total++; if (bus.rsp_rdata !== 32'h0) begin bad++; $display("FAIL sb_rdata: got %h want 0", bus.rsp_rdata); end
    total++; if (bus.rsp_err !== 1'b0) begin bad++; $display("FAIL sb_err: got %b want 0", bus.rsp_err); end
    total++; if (rd_pulses - rd0 !== 0 || wr_pulses - wr0 !== 1) begin bad++; $display("FAIL sb_pulses: got rd=%0d wr=%0d want rd=0 wr=1", rd_pulses - rd0, wr_pulses - wr0); end
    finish_rsp("sb");
    settle_mem();
  endtask

  // Alignment table: error cases answer one edge after the handshake with no strobe.
  localparam int N_AL = 7;
  localparam logic        AL_WE   [N_AL] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam logic [31:0] AL_ADDR [N_AL] = '{32'h4003, 32'h4002, 32'h4001, 32'h4000, 32'h2001, 32'h4002, 32'h4003};
  localparam logic [1:0]  AL_SIZE [N_AL] = '{2'd1, 2'd2, 2'd2, 2'd3, 2'd1, 2'd1, 2'd0};
  localparam logic        AL_SGN  [N_AL] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam logic        AL_ERR  [N_AL] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  localparam logic [3:0]  AL_MASK [N_AL] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hB, 4'h1};

  task automatic test_alignment;
    int lat, rd0, wr0;
    for (int i = 0; i < N_AL; i++) begin
      rd0 = rd_pulses; wr0 = wr_pulses;
      rd_value = 32'h0000_FF80 + i; stall_len = 2;
      send(AL_WE[i], AL_ADDR[i], 32'h1234_5678, AL_SIZE[i], AL_SGN[i]);
      wait_rsp(lat);
      total++; if (bus.rsp_err !== AL_ERR[i]) begin bad++; $display("FAIL align%0d_err: got %b want %b", i, bus.rsp_err, AL_ERR[i]); end
      if (AL_ERR[i]) begin
        total++; if (lat !== 1) begin bad++; $display("FAIL align%0d_latency: got %0d want 1", i, lat); end
        total++; if (bus.rsp_rdata !== 32'h0) begin bad++; $display("FAIL align%0d_rdata: got %h want 0", i, bus.rsp_rdata); end
      end else begin
        total++; if (lat !== 5) begin bad++; $display("FAIL align%0d_latency: got %0d want 5", i, lat); end
        total++; if (bus.rsp_rdata !== 32'h0000_FF80 + i) begin bad++; $display("FAIL align%0d_rdata: got %h want %h", i, bus.rsp_rdata, 32'h0000_FF80 + i); end
        total++; if (mem_sign_mask !== AL_MASK[i]) begin bad++; $display("FAIL align%0d_mask: got %h want %h", i, mem_sign_mask, AL_MASK[i]); end
      end
      finish_rsp("align");
      settle_mem();
      total++;
      if ((rd_pulses - rd0) + (wr_pulses - wr0) !== (AL_ERR[i] ? 0 : 1)) begin
        bad++; $display("FAIL align%0d_pulses: got %0d want %0d", i, (rd_pulses - rd0) + (wr_pulses - wr0), AL_ERR[i] ? 0 : 1);
      end
    end
  endtask

  task automatic test_timeout;
    int lat, rd0;
    rd0 = rd_pulses;
    mem_dead = 1'b1;
    // 1 handshake edge + 1 ISSUE cycle + 15 wait cycles.
    send(1'b0, 32'h0000_4000, 32'h0, 2'd2, 1'b0);
    wait_rsp(lat);
    total++; if (lat !== 17) begin bad++; $display("FAIL to_latency: got %0d want 17", lat); end
    total++; if (bus.rsp_err !== 1'b1) begin bad++; $display("FAIL to_err: got %b want 1", bus.rsp_err); end
    total++; if (bus.rsp_rdata !== 32'h0) begin bad++; $display("FAIL to_rdata: got %h want 0", bus.rsp_rdata); end
    total++; if (rd_pulses - rd0 !== 1) begin bad++; $display("FAIL to_pulses: got %0d want 1", rd_pulses - rd0); end
    finish_rsp("to");
    mem_dead = 1'b0;
    settle_mem();
  endtask

  task automatic test_backpressure;
    int lat;
    rd_value = 32'h1234_5678; stall_len = 2;
    send(1'b0, 32'h0000_4008, 32'h0, 2'd2, 1'b0);
    wait_rsp(lat);
    bus.req_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL bp%0d_valid: got %b want 1", c, bus.rsp_valid); end
      total++; if (bus.rsp_rdata !== 32'h1234_5678) begin bad++; $display("FAIL bp%0d_rdata: got %h want 12345678", c, bus.rsp_rdata); end
      total++; if (bus.rsp_err !== 1'b0) begin bad++; $display("FAIL bp%0d_err: got %b want 0", c, bus.rsp_err); end
      total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL bp%0d_req_ready: got %b want 0", c, bus.req_ready); end
      total++; if (mem_addr !== 32'h0000_4008 || mem_sign_mask !== 4'h7) begin bad++; $display("FAIL bp%0d_mem_hold: got %h/%h want 00004008/7", c, mem_addr, mem_sign_mask); end
      total++; if (mem_memread !== 1'b0) begin bad++; $display("FAIL bp%0d_memread: got %b want 0", c, mem_memread); end
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    finish_rsp("bp");
    settle_mem();
  endtask

  task automatic test_reset_mid;
    int lat, n, seen;
    rd_value = 32'h1111_2222; stall_len = 4;
    send(1'b0, 32'h0000_400C, 32'h0, 2'd2, 1'b0);
    n = 0;
    while (!mem_clk_stall && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    total++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL rm_handshake: got ready=%b valid=%b want 1/0", bus.req_ready, bus.rsp_valid); end
    total++; if (mem_addr !== 32'h0 || mem_sign_mask !== 4'h0) begin bad++; $display("FAIL rm_mem_bus: got %h/%h want 0/0", mem_addr, mem_sign_mask); end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid === 1'b1) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL rm_no_rsp: got %0d want 0", seen); end
    settle_mem();
    rd_value = 32'hCAFE_F00D; stall_len = 2;
    send(1'b0, 32'h0000_4010, 32'h0, 2'd2, 1'b0);
    wait_rsp(lat);
    total++; if (lat !== 5) begin bad++; $display("FAIL rm_after_latency: got %0d want 5", lat); end
    total++; if (bus.rsp_rdata !== 32'hCAFE_F00D) begin bad++; $display("FAIL rm_after_rdata: got %h want cafef00d", bus.rsp_rdata); end
    finish_rsp("rm");
    settle_mem();
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_store_byte();
    test_alignment();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
